// File: rtl/elevator_pkg.sv
// Shared types and helpers for the 3-floor elevator scheduler.
//   state_t        : controller states IDLE / MOVE / DOOR
//   FLOOR_1..3     : floor codes 2'b00 / 2'b01 / 2'b10 (2'b11 never used)
//   floor_mask()   : floor code -> one-hot request bit
//   nearest_ahead(): nearest pending floor strictly ahead of a floor in a direction,
//                    returned as {found, floor_code}
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic [1:0] FLOOR_1 = 2'b00;
  localparam logic [1:0] FLOOR_2 = 2'b01;
  localparam logic [1:0] FLOOR_3 = 2'b10;
  localparam int NUM_FLOORS = 3;

  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [1:0] f);
    logic [NUM_FLOORS-1:0] m;
    case (f)
      FLOOR_1: m = 3'b001;
      FLOOR_2: m = 3'b010;
      FLOOR_3: m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] nearest_ahead(input logic [NUM_FLOORS-1:0] req,
                                                input logic [1:0] cur,
                                                input logic dir);
    logic [2:0] r;
    r = 3'b000;
    if (dir) begin
      if (cur == FLOOR_1) begin
        if (req[1])      r = {1'b1, FLOOR_2};
        else if (req[2]) r = {1'b1, FLOOR_3};
      end else if (cur == FLOOR_2) begin
        if (req[2])      r = {1'b1, FLOOR_3};
      end
    end else begin
      if (cur == FLOOR_3) begin
        if (req[1])      r = {1'b1, FLOOR_2};
        else if (req[0]) r = {1'b1, FLOOR_1};
      end else if (cur == FLOOR_2) begin
        if (req[0])      r = {1'b1, FLOOR_1};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Down-counting tick timer with terminal-count flag.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : load load_val (takes priority over run)
//   run        : decrement while nonzero
//   load_val   : reload value (ticks - 1)
//   tc         : count == 0; a load of N-1 gives tc after N-1 run cycles,
//                so the owner sees one period of N cycles
module elev_tick_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car, 3-floor elevator controller with SCAN goal selection.
// Optional feature macro: ELEV_DOOR_HOLD_EN (door_hold freezes door dwell).
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   req[2:0]    : pending call levels, bit i = floor code i
//   door_hold   : keep door open (only with ELEV_DOOR_HOLD_EN)
//   goal_floor  : target floor code
//   moving      : car travelling between floors
//   dir_up      : current / last travel direction
//   cur_floor   : floor the car is at or last passed
//   door_open   : door open (DOOR state)
//   clear_req   : one-cycle pulse for the floor just served
//
// state | meaning
// IDLE  | door closed, waiting for a call; picks direction and goal
// MOVE  | travelling, one floor per FLOOR_TICKS cycles
// DOOR  | door open for DOOR_TICKS cycles, own-floor calls restart dwell
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 16,
  parameter int DOOR_TICKS  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       door_hold,
  output logic [1:0] goal_floor,
  output logic       moving,
  output logic       dir_up,
  output logic [1:0] cur_floor,
  output logic       door_open,
  output logic [2:0] clear_req
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW = $clog2(MAX_TICKS);
  localparam logic [TW-1:0] STEP_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_TICKS - 1);

  state_t     state, state_n;
  logic [1:0] cur_n, goal_n;
  logic       dir_n;
  logic [2:0] clear_n;
  logic       step_load, door_load, step_tc, door_tc;
  logic       hold_door;
  logic [1:0] next_cur;
  logic [2:0] pick_up, pick_dn, pick_step;
  logic       dir_sel;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold_door = door_hold;
`else
  logic unused_door_hold;
  assign unused_door_hold = door_hold;
  assign hold_door = 1'b0;
`endif

  elev_tick_timer #(.WIDTH(TW)) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (step_load),
    .run      (state == MOVE),
    .load_val (STEP_LOAD),
    .tc       (step_tc)
  );

  elev_tick_timer #(.WIDTH(TW)) u_door_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (door_load),
    .run      (state == DOOR),
    .load_val (DOOR_LOAD),
    .tc       (door_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_floor  <= FLOOR_1;
      goal_floor <= FLOOR_1;
      dir_up     <= 1'b1;
      clear_req  <= 3'b000;
    end else begin
      state      <= state_n;
      cur_floor  <= cur_n;
      goal_floor <= goal_n;
      dir_up     <= dir_n;
      clear_req  <= clear_n;
    end
  end

  always_comb begin
    state_n   = state;
    cur_n     = cur_floor;
    goal_n    = goal_floor;
    dir_n     = dir_up;
    clear_n   = 3'b000;
    step_load = 1'b0;
    door_load = 1'b0;

    pick_up = nearest_ahead(req, cur_floor, 1'b1);
    pick_dn = nearest_ahead(req, cur_floor, 1'b0);

    // SCAN: keep direction while something is ahead, otherwise reverse;
    // the end floors force the only possible direction.
    if (cur_floor == FLOOR_3)      dir_sel = 1'b0;
    else if (cur_floor == FLOOR_1) dir_sel = 1'b1;
    else if (dir_up)               dir_sel = pick_up[2];
    else                           dir_sel = ~pick_dn[2];

    if (dir_up && (cur_floor != FLOOR_3))       next_cur = cur_floor + 2'd1;
    else if (!dir_up && (cur_floor != FLOOR_1)) next_cur = cur_floor - 2'd1;
    else                                        next_cur = cur_floor;

    pick_step = nearest_ahead(req, next_cur, dir_up);

    case (state)
      IDLE: begin
        if ((req & floor_mask(cur_floor)) != 3'b000) begin
          state_n   = DOOR;
          clear_n   = floor_mask(cur_floor);
          door_load = 1'b1;
        end else if (req != 3'b000) begin
          dir_n     = dir_sel;
          goal_n    = dir_sel ? pick_up[1:0] : pick_dn[1:0];
          state_n   = MOVE;
          step_load = 1'b1;
        end
      end

      MOVE: begin
        if (step_tc) begin
          step_load = 1'b1;
          cur_n     = next_cur;
          if ((req & floor_mask(next_cur)) != 3'b000) begin
            // arrival at a pending floor, including a retarget to a nearer call
            goal_n    = next_cur;
            state_n   = DOOR;
            clear_n   = floor_mask(next_cur);
            door_load = 1'b1;
          end else if (pick_step[2]) begin
            goal_n = pick_step[1:0];
          end else begin
            // goal call withdrawn and nothing further ahead: stop here
            state_n   = DOOR;
            door_load = 1'b1;
          end
        end
      end

      DOOR: begin
        // clear_req still high means the button block has not yet dropped the
        // call we just served; do not treat it as a fresh request.
        if (((req & floor_mask(cur_floor)) != 3'b000) &&
            ((clear_req & floor_mask(cur_floor)) == 3'b000)) begin
          clear_n   = floor_mask(cur_floor);
          door_load = 1'b1;
        end else if (hold_door) begin
          door_load = 1'b1;
        end else if (door_tc) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       door_hold = 1'b0;
  logic [1:0] goal_floor;
  logic       moving;
  logic       dir_up;
  logic [1:0] cur_floor;
  logic       door_open;
  logic [2:0] clear_req;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(.FLOOR_TICKS(4), .DOOR_TICKS(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .door_hold  (door_hold),
    .goal_floor (goal_floor),
    .moving     (moving),
    .dir_up     (dir_up),
    .cur_floor  (cur_floor),
    .door_open  (door_open),
    .clear_req  (clear_req)
  );

  typedef struct {
    logic [2:0] set_req;
    int         n;
    logic [1:0] cur;
    logic [1:0] goal;
    logic       mov;
    logic       door;
    logic       dir;
    logic [2:0] clr;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // one clock: sample 1 ns after the edge, then let the button block drop served calls
  task automatic tick();
    @(posedge clk);
    #1;
    chk("clr_while_moving", 32'(moving & (|clear_req)), 32'd0);
    req = req & ~clear_req;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 3'b000;
    door_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] cur, input logic [1:0] goal,
                           input logic mov, input logic door, input logic [2:0] clr);
    chk({tag, "_cur"},  32'(cur_floor),  32'(cur));
    chk({tag, "_goal"}, 32'(goal_floor), 32'(goal));
    chk({tag, "_mov"},  32'(moving),     32'(mov));
    chk({tag, "_door"}, 32'(door_open),  32'(door));
    chk({tag, "_clr"},  32'(clear_req),  32'(clr));
  endtask

  initial begin
    //           set     n  cur   goal  mov   door  dir   clr
    vecs[0]  = '{3'b000, 1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[1]  = '{3'b100, 1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 3'b000};
    vecs[2]  = '{3'b000, 3, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 3'b000};
    vecs[3]  = '{3'b000, 1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 3'b000};
    vecs[4]  = '{3'b000, 4, 2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 3'b100};
    vecs[5]  = '{3'b000, 1, 2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 3'b000};
    vecs[6]  = '{3'b000, 4, 2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 3'b000};
    vecs[7]  = '{3'b000, 1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[8]  = '{3'b010, 1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 3'b000};
    vecs[9]  = '{3'b000, 4, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 3'b010};
    vecs[10] = '{3'b000, 5, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 3'b000};
    vecs[11] = '{3'b000, 1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[12] = '{3'b101, 1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 3'b000};
    vecs[13] = '{3'b000, 4, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3'b001};
    vecs[14] = '{3'b000, 6, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[15] = '{3'b000, 1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 3'b000};
    vecs[16] = '{3'b000, 8, 2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 3'b100};

    // reset values while held in reset
    repeat (2) @(posedge clk);
    #1;
    chk_state("rst", 2'd0, 2'd0, 1'b0, 1'b0, 3'b000);
    chk("rst_dir", 32'(dir_up), 32'd1);

    // table: 0->2, 2->1, SCAN down from 1 with calls at 0 and 2
    do_reset();
    for (int i = 0; i < 17; i++) begin
      req = req | vecs[i].set_req;
      run(vecs[i].n);
      chk_state($sformatf("v%0d", i), vecs[i].cur, vecs[i].goal, vecs[i].mov,
                vecs[i].door, vecs[i].clr);
      chk($sformatf("v%0d_dir", i), 32'(dir_up), 32'(vecs[i].dir));
    end

    // retarget 0->2 to floor 1, then door restart at floor 2
    do_reset();
    req = 3'b100;
    run(2);
    req = req | 3'b010;
    run(2);
    chk_state("rt_e3", 2'd0, 2'd2, 1'b1, 1'b0, 3'b000);
    run(1);
    chk_state("rt_e4", 2'd1, 2'd1, 1'b0, 1'b1, 3'b010);
    run(6);
    chk_state("rt_e10", 2'd1, 2'd1, 1'b0, 1'b0, 3'b000);
    run(1);
    chk_state("rt_e11", 2'd1, 2'd2, 1'b1, 1'b0, 3'b000);
    chk("rt_e11_dir", 32'(dir_up), 32'd1);
    run(4);
    chk_state("rt_e15", 2'd2, 2'd2, 1'b0, 1'b1, 3'b100);
    run(4);
    req = req | 3'b100;
    run(1);
    chk_state("dr_e20", 2'd2, 2'd2, 1'b0, 1'b1, 3'b100);
    run(5);
    chk_state("dr_e25", 2'd2, 2'd2, 1'b0, 1'b1, 3'b000);
    run(1);
    chk("dr_e26_door", 32'(door_open), 32'd0);

    // door hold at floor 2
    req = req | 3'b100;
    run(1);
    chk_state("hd_e27", 2'd2, 2'd2, 1'b0, 1'b1, 3'b100);
    door_hold = 1'b1;
`ifdef ELEV_DOOR_HOLD_EN
    run(13);
    chk("hd_e40_door", 32'(door_open), 32'd1);
    run(7);
    chk("hd_e47_door", 32'(door_open), 32'd1);
    door_hold = 1'b0;
    run(5);
    chk("hd_e52_door", 32'(door_open), 32'd1);
    run(1);
    chk("hd_e53_door", 32'(door_open), 32'd0);
`else
    run(5);
    chk("hd_e32_door", 32'(door_open), 32'd1);
    run(1);
    chk("hd_e33_door", 32'(door_open), 32'd0);
    run(14);
    door_hold = 1'b0;
    chk("hd_e47_door", 32'(door_open), 32'd0);
`endif

    // SCAN: at floor 1 going up with calls at 0 and 2 -> 2 first
    do_reset();
    req = 3'b010;
    run(1);
    chk_state("sc_e0", 2'd0, 2'd1, 1'b1, 1'b0, 3'b000);
    run(4);
    chk_state("sc_e4", 2'd1, 2'd1, 1'b0, 1'b1, 3'b010);
    run(2);
    req = req | 3'b101;
    run(1);
    chk_state("sc_e7", 2'd1, 2'd1, 1'b0, 1'b1, 3'b000);
    run(3);
    chk_state("sc_e10", 2'd1, 2'd1, 1'b0, 1'b0, 3'b000);
    run(1);
    chk_state("sc_e11", 2'd1, 2'd2, 1'b1, 1'b0, 3'b000);
    chk("sc_e11_dir", 32'(dir_up), 32'd1);
    run(4);
    chk_state("sc_e15", 2'd2, 2'd2, 1'b0, 1'b1, 3'b100);
    run(7);
    chk_state("sc_e22", 2'd2, 2'd0, 1'b1, 1'b0, 3'b000);
    chk("sc_e22_dir", 32'(dir_up), 32'd0);
    run(8);
    chk_state("sc_e30", 2'd0, 2'd0, 1'b0, 1'b1, 3'b001);

    // call withdrawn mid-trip: stop at next floor without a clear pulse
    do_reset();
    req = 3'b100;
    run(2);
    req = 3'b000;
    run(3);
    chk("drop_cur", 32'(cur_floor), 32'd1);
    chk("drop_mov", 32'(moving), 32'd0);
    chk("drop_door", 32'(door_open), 32'd1);
    chk("drop_clr", 32'(clear_req), 32'd0);

    // asynchronous reset mid-travel
    do_reset();
    req = 3'b100;
    run(6);
    chk("ar_pre_cur", 32'(cur_floor), 32'd1);
    chk("ar_pre_mov", 32'(moving), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("ar", 2'd0, 2'd0, 1'b0, 1'b0, 3'b000);
    chk("ar_dir", 32'(dir_up), 32'd1);
    req = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    run(3);
    chk_state("ar_post", 2'd0, 2'd0, 1'b0, 1'b0, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
